// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, frame constants and baud divisor helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int END_SAMPLE = 15;
    localparam int DATA_BITS  = 8;

    // Rounded clocks-per-tick; the half-divisor term gives round-to-nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        longint den;
        den = longint'(baud) * longint'(OVERSAMPLE);
        return int'((longint'(clk_hz) + den / 2) / den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running 0..DIV-1 counter, one-cycle tick at DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 65
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] cnt_q;
    logic [c_cw-1:0] cnt_d;

    assign tick = (cnt_q == c_last);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x oversampling 8N1 serial receiver with valid/frame_err
//                strobes. Define UART_RX_PARITY_EN for 8E1 and parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int         c_div = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] c_mid = 4'(MID_SAMPLE);
    localparam logic [3:0] c_end = 4'(END_SAMPLE);
    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

    logic       rx_s1_q, rx_s2_q, rx_s;
    logic       tick, clr;
    state_e     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       frame_err_q, frame_err_d;
    logic       par_bad_q, par_bad_d;
    logic       parity_err_q, parity_err_d;

    assign rx_s = rx_s2_q;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        par_bad_d    = par_bad_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        clr          = 1'b0;
        if (tick) begin
            sc_d = sc_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    sc_d      = '0;
                    par_bad_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            START: begin
                if (tick && sc_q == c_mid) begin
                    sc_d      = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && sc_q == c_end) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (tick && sc_q == c_end) begin
                    par_bad_d = (rx_s != ^shift_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick && sc_q == c_end) begin
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line idles so a held-low line yields one error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            state_q      <= IDLE;
            sc_q         <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q ^ par_bad_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed and random frames against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 4;          // round(6.4e6 / 1.6e6)
    localparam int BIT      = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Stop bit is sampled mid-bit; 3 cycles of sync + detect come on top.
    localparam int LATENCY = (FRAME_BITS - 1) * BIT + BIT / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err;
    logic       parity_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0, fcnt = 0, pcnt = 0, both = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    int exp_v = 0, exp_f = 0, exp_p = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .frame_err  (frame_err)
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid) begin
            vcnt           <= vcnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err)          fcnt <= fcnt + 1;
        if (parity_err)         pcnt <= pcnt + 1;
        if (valid && frame_err) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level outcome straight from the frame rules.
    task automatic model(input logic [7:0] b, input logic par, input logic stop_ok);
        logic par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = (par == ^b);
`else
        par_ok = 1'b1 | par;
`endif
        if (!stop_ok)     exp_f++;
        else if (!par_ok) exp_p++;
        else begin
            exp_v++;
            exp_data = b;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b, input logic par);
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold(par, BIT);
`else
        if (par) rx = 1'b0;
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stop_ok, input int gap);
        send_head(b, par);
        hold(stop_ok, BIT);
        hold(1'b1, gap);
        if (!stop_ok) hold(1'b1, 4);
        model(b, par, stop_ok);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_cnt"}, vcnt, exp_v);
        chk({tag, ".ferr_cnt"},  fcnt, exp_f);
        chk({tag, ".perr_cnt"},  pcnt, exp_p);
        chk({tag, ".data"},      {24'd0, data}, {24'd0, exp_data});
        chk({tag, ".exclusive"}, both, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_ok, par;
        int         lat;

        repeat (3) @(negedge clk);
        chk("reset.data",  {24'd0, data}, 0);
        chk("reset.valid", {31'd0, valid}, 0);
        chk("reset.busy",  {31'd0, busy}, 0);
        chk("reset.ferr",  {31'd0, frame_err}, 0);
        chk("reset.perr",  {31'd0, parity_err}, 0);
        rst = 1'b0;
        hold(1'b1, 2 * BIT);

        // Single frame, with latency check.
        send_frame(8'hAA, ^8'hAA, 1'b1, 0);
        lat = last_valid_cyc - start_cyc;
        chk("aa.latency_ok", {31'd0, (lat >= LATENCY - 2 && lat <= LATENCY + 2)}, 1);
        check_all("aa");

        // Back-to-back with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 0);
        chk("b2b0.data", {24'd0, data}, 32'h00);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        check_all("b2b");

        // False start: 3 ticks low.
        hold(1'b0, 3 * DIV);
        chk("false.busy_hi", {31'd0, busy}, 1);
        hold(1'b1, BIT);
        chk("false.busy_lo", {31'd0, busy}, 0);
        check_all("false");

        // Stop held low for three bit times.
        send_head(8'h55, ^8'h55);
        hold(1'b0, 3 * BIT);
        model(8'h55, ^8'h55, 1'b0);
        chk("brk.busy_hold", {31'd0, busy}, 1);
        check_all("brk");
        hold(1'b1, 4);
        chk("brk.busy_rel", {31'd0, busy}, 0);
        hold(1'b1, BIT);

        // Reset during data bit 4.
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(i[0], BIT);
        hold(1'b0, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.data",  {24'd0, data}, 0);
        chk("rst.valid", {31'd0, valid}, 0);
        chk("rst.busy",  {31'd0, busy}, 0);
        chk("rst.ferr",  {31'd0, frame_err}, 0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        hold(1'b1, BIT);
        send_frame(8'h3C, ^8'h3C, 1'b1, 0);
        check_all("post_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1, 2);
        check_all("par_bad");
        send_frame(8'h07, 1'b1, 1'b1, 2);
        check_all("par_good");
`endif

        for (int n = 0; n < 12; n++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            par     = ^b ^ ($urandom_range(0, 3) == 0);
            send_frame(b, par, stop_ok, $urandom_range(0, 3));
            check_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
